// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state encoding for the instruction fetch stage
package fetch_pkg;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_soft_reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // count up on inc, hold once every bit is set
  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: drives sync instruction memory, hands words to decode
module instruction_fetch #(
  parameter int CONTADOR_LENGTH    = 11,
  parameter int INSTRUCTION_LENGTH = 32,
  parameter int COUNT_LENGTH       = 16,
  parameter logic [INSTRUCTION_LENGTH-1:0] HALT_WORD = fetch_pkg::HALT_WORD
) (
  input  logic                          i_clock,
  input  logic                          i_soft_reset,
  input  logic                          i_enable,
  input  logic                          i_stall,
  input  logic                          i_flush,
  input  logic [CONTADOR_LENGTH-1:0]    i_pc,
  output logic                          o_pc_enable,
  output logic [CONTADOR_LENGTH-1:0]    o_mem_addr,
  output logic                          o_mem_en,
  input  logic [INSTRUCTION_LENGTH-1:0] i_mem_data,
  output logic [INSTRUCTION_LENGTH-1:0] o_instruction,
  output logic [CONTADOR_LENGTH-1:0]    o_pc_plus_1,
  output logic                          o_valid,
  output logic                          o_halted,
  output logic [COUNT_LENGTH-1:0]       o_fetch_count
);

  import fetch_pkg::NOP_WORD;
  import fetch_pkg::fetch_state_t;
  import fetch_pkg::IDLE;
  import fetch_pkg::RUN;
  import fetch_pkg::HALTED;

  fetch_state_t                 state;
  logic [CONTADOR_LENGTH-1:0]   fetched_pc;
  logic                         issued;
  logic                         valid_q;
  logic                         shown;
  logic                         halt_seen;
  logic                         issue;
  logic                         accept;

  // a word is on the memory output only after at least one address went out
  assign shown     = valid_q & issued;
  assign halt_seen = (state == RUN) & shown & (i_mem_data == HALT_WORD) & ~i_flush;
  assign issue     = (state == RUN) & i_enable & ~i_stall & ~halt_seen;
  assign accept    = shown & ~i_stall & i_enable & ~i_flush;

  assign o_mem_addr    = i_pc;
  assign o_mem_en      = issue;
  assign o_pc_enable   = issue;
  assign o_valid       = valid_q;
  assign o_halted      = (state == HALTED);
  assign o_instruction = shown ? i_mem_data : INSTRUCTION_LENGTH'(NOP_WORD);
  assign o_pc_plus_1   = fetched_pc + 1'b1;

  // run-control FSM: start on enable, stop for good on a delivered halt word
  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (i_enable) state <= RUN;
        RUN:     if (halt_seen) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  // track which address is in flight and whether its word is deliverable
  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset) begin
      fetched_pc <= '0;
      issued     <= 1'b0;
      valid_q    <= 1'b0;
    end else if (issue) begin
      fetched_pc <= i_pc;
      issued     <= 1'b1;
      valid_q    <= ~i_flush;
    end else if (i_flush || halt_seen) begin
      valid_q    <= 1'b0;
    end
  end

  sat_counter #(
    .WIDTH (COUNT_LENGTH)
  ) u_fetch_count (
    .i_clock      (i_clock),
    .i_soft_reset (i_soft_reset),
    .inc          (accept),
    .count        (o_fetch_count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;

  localparam int CL      = 11;
  localparam int IL      = 32;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int PC_MOD  = 1 << CL;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic            i_clock = 1'b0;
  logic            i_soft_reset = 1'b1;
  logic            i_enable = 1'b0;
  logic            i_stall = 1'b0;
  logic            i_flush = 1'b0;
  logic [CL-1:0]   pc_q;
  logic            o_pc_enable;
  logic [CL-1:0]   o_mem_addr;
  logic            o_mem_en;
  logic [IL-1:0]   rom_q;
  logic [IL-1:0]   o_instruction;
  logic [CL-1:0]   o_pc_plus_1;
  logic            o_valid;
  logic            o_halted;
  logic [CNT_W-1:0] o_fetch_count;

  logic [IL-1:0]   rom [0:PC_MOD-1];
  logic [CL-1:0]   pc_reset_val = '0;
  logic [CL-1:0]   flush_target = '0;
  bit              rand_targets = 1'b0;

  int passed = 0;
  int total  = 0;

  // model: 0 idle, 1 running, 2 halted; which word is on show; accepted count
  int m_mode, m_pc, m_count;
  bit m_show;

  instruction_fetch #(
    .CONTADOR_LENGTH    (CL),
    .INSTRUCTION_LENGTH (IL),
    .COUNT_LENGTH       (CNT_W),
    .HALT_WORD          (HALT)
  ) dut (
    .i_clock       (i_clock),
    .i_soft_reset  (i_soft_reset),
    .i_enable      (i_enable),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .i_pc          (pc_q),
    .o_pc_enable   (o_pc_enable),
    .o_mem_addr    (o_mem_addr),
    .o_mem_en      (o_mem_en),
    .i_mem_data    (rom_q),
    .o_instruction (o_instruction),
    .o_pc_plus_1   (o_pc_plus_1),
    .o_valid       (o_valid),
    .o_halted      (o_halted),
    .o_fetch_count (o_fetch_count)
  );

  always #5 i_clock = ~i_clock;

  // synchronous ROM, output held while not enabled
  always @(posedge i_clock) if (o_mem_en) rom_q <= rom[o_mem_addr];

  // PC register: branch target on flush, else step when fetch allows
  always @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset)     pc_q <= pc_reset_val;
    else if (i_flush)     pc_q <= flush_target;
    else if (o_pc_enable) pc_q <= pc_q + 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_show = 0; m_pc = 0; m_count = 0;
  endtask

  task automatic fill_rom(input int halt_pct);
    for (int i = 0; i < PC_MOD; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = 32'h0;
      rom[i] = ($urandom_range(99) < halt_pct) ? HALT : w;
    end
  endtask

  // one clock: apply inputs, compare against the model, advance the model
  task automatic cycle(input bit en, input bit st, input bit fl);
    bit halt_now, fetch, accept;
    i_enable = en; i_stall = st; i_flush = fl;
    flush_target = rand_targets ? CL'($urandom_range(PC_MOD - 1)) : pc_q + 1'b1;
    #1;
    halt_now = (m_mode == 1) && m_show && (rom[m_pc] == HALT) && !fl;
    fetch    = (m_mode == 1) && en && !st && !halt_now;
    accept   = m_show && en && !st && !fl;
    chk("mem_addr",    32'(o_mem_addr), 32'(pc_q));
    chk("mem_en",      32'(o_mem_en), 32'(fetch));
    chk("pc_enable",   32'(o_pc_enable), 32'(fetch));
    chk("valid",       32'(o_valid), 32'(m_show));
    chk("instruction", o_instruction, m_show ? rom[m_pc] : 32'h0);
    chk("pc_plus_1",   32'(o_pc_plus_1), 32'((m_pc + 1) % PC_MOD));
    chk("halted",      32'(o_halted), 32'(m_mode == 2));
    chk("fetch_count", 32'(o_fetch_count), 32'(m_count));
    if (accept && m_count < CNT_MAX) m_count++;
    if (fetch) begin
      m_pc   = int'(pc_q);
      m_show = !fl;
    end else if (fl || halt_now) begin
      m_show = 0;
    end
    if (m_mode == 0 && en) m_mode = 1;
    else if (m_mode == 1 && halt_now) m_mode = 2;
    @(posedge i_clock);
    #1;
  endtask

  task automatic do_reset(input logic [CL-1:0] pc0);
    i_soft_reset = 1'b1;
    pc_reset_val = pc0;
    i_enable = 0; i_stall = 0; i_flush = 0;
    model_reset();
    @(negedge i_clock);
    @(negedge i_clock);
    i_soft_reset = 1'b0;
  endtask

  task automatic directed_rom();
    fill_rom(0);
    for (int i = 0; i < 5; i++) rom[i] = 32'(i + 1);
    rom[5] = HALT;
  endtask

  initial begin
    model_reset();
    rand_targets = 0;
    directed_rom();

    // reset state, then four consecutive deliveries and a halt
    do_reset('0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_count", 32'(o_fetch_count), 32'h0);
    chk("rst_halted", 32'(o_halted), 32'h0);
    chk("rst_instr", o_instruction, 32'h0);
    cycle(1, 0, 0); cycle(1, 0, 0);
    chk("t1_instr_c2", o_instruction, 32'd1);
    chk("t1_pp1_c2", 32'(o_pc_plus_1), 32'd1);
    cycle(1, 0, 0); chk("t1_instr_c3", o_instruction, 32'd2);
    cycle(1, 0, 0); chk("t1_instr_c4", o_instruction, 32'd3);
    cycle(1, 0, 0); chk("t1_instr_c5", o_instruction, 32'd4);
    chk("t1_pp1_c5", 32'(o_pc_plus_1), 32'd4);
    cycle(1, 0, 0); chk("t1_count_c6", 32'(o_fetch_count), 32'd4);
    cycle(1, 0, 0); chk("t4_halt_word", o_instruction, HALT);
    cycle(1, 0, 0);
    chk("t4_halted", 32'(o_halted), 32'd1);
    chk("t4_valid", 32'(o_valid), 32'd0);
    chk("t4_pc", 32'(pc_q), 32'd6);
    chk("t4_count", 32'(o_fetch_count), 32'd6);
    cycle(0, 0, 0); cycle(1, 0, 0); cycle(0, 0, 0); cycle(1, 0, 0);
    chk("t4_sticky", 32'(o_halted), 32'd1);
    chk("t4_pc_hold", 32'(pc_q), 32'd6);

    // stall while instruction 2 is shown
    do_reset('0);
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(1, 0, 0);
    cycle(1, 1, 0); chk("t2_hold1", o_instruction, 32'd2);
    cycle(1, 1, 0); chk("t2_hold2", o_instruction, 32'd2);
    cycle(1, 1, 0); chk("t2_hold3", o_instruction, 32'd2);
    chk("t2_count_once", 32'(o_fetch_count), 32'd1);
    cycle(1, 0, 0); chk("t2_next", o_instruction, 32'd3);
    chk("t2_count", 32'(o_fetch_count), 32'd2);

    // flush, then flush together with stall
    do_reset('0);
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(1, 0, 0);
    cycle(1, 0, 1);
    chk("t3_valid", 32'(o_valid), 32'd0);
    chk("t3_instr", o_instruction, 32'd0);
    chk("t3_count", 32'(o_fetch_count), 32'd1);
    cycle(1, 0, 0); chk("t3_refetch", o_instruction, 32'd4);
    cycle(1, 1, 1);
    chk("t3_fs_valid", 32'(o_valid), 32'd0);
    chk("t3_fs_instr", o_instruction, 32'd0);
    chk("t3_fs_count", 32'(o_fetch_count), 32'd1);

    // asynchronous reset in the middle of a stalled cycle
    do_reset('0);
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(1, 0, 0);
    i_stall = 1'b1; i_enable = 1'b1;
    #2;
    i_soft_reset = 1'b1;
    #1;
    chk("t6_valid", 32'(o_valid), 32'd0);
    chk("t6_instr", o_instruction, 32'd0);
    chk("t6_count", 32'(o_fetch_count), 32'd0);
    chk("t6_halted", 32'(o_halted), 32'd0);
    chk("t6_pc_enable", 32'(o_pc_enable), 32'd0);
    chk("t6_mem_en", 32'(o_mem_en), 32'd0);
    model_reset();
    @(negedge i_clock);
    i_soft_reset = 1'b0;
    cycle(1, 0, 0); cycle(1, 0, 0);
    chk("t6_restart_instr", o_instruction, 32'd1);
    chk("t6_restart_pp1", 32'(o_pc_plus_1), 32'd1);

    // address wrap at the top of the PC range
    do_reset(CL'(PC_MOD - 1));
    rom[PC_MOD - 1] = 32'h1234_5678;
    cycle(1, 0, 0); cycle(1, 0, 0);
    chk("t5_wrap_pp1", 32'(o_pc_plus_1), 32'd0);
    chk("t5_wrap_instr", o_instruction, 32'h1234_5678);

    // count saturation under long halt-free run
    fill_rom(0);
    do_reset(CL'(100));
    for (int i = 0; i < 200; i++) cycle(1, $urandom_range(9) == 0, 0);
    chk("t5_saturate", 32'(o_fetch_count), 32'(CNT_MAX));

    // randomized segments with random branch targets and occasional async reset
    rand_targets = 1;
    for (int seg = 0; seg < 8; seg++) begin
      fill_rom(3);
      do_reset(CL'($urandom_range(PC_MOD - 1)));
      for (int i = 0; i < 150; i++) begin
        if (seg[0] && i == 75) begin
          #2;
          i_soft_reset = 1'b1;
          #1;
          chk("rand_async_valid", 32'(o_valid), 32'd0);
          model_reset();
          @(negedge i_clock);
          i_soft_reset = 1'b0;
        end
        cycle($urandom_range(9) != 0, $urandom_range(4) == 0, $urandom_range(9) == 0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
